// File: rtl/ddp_ps_pkg.sv
// Shared definitions for the JOIN->PS pipeline: default field widths, PS opcodes
// and helpers that slice the fields of an input packet {CG, dest, CZDD}.
package ddp_ps_pkg;

  localparam int CG_W      = 11;
  localparam int DEST_W    = 7;
  localparam int CZDD_W    = 34;
  localparam int PSD_W     = 17;
  localparam int OPC_W     = 6;
  localparam int PKT_IN_W  = CG_W + DEST_W + CZDD_W;
  localparam int PKT_OUT_W = CG_W + PSD_W + CZDD_W;

  localparam logic [OPC_W-1:0] OPC_NOP  = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ADDC = 6'h01;
  localparam logic [OPC_W-1:0] OPC_SUBC = 6'h02;
  localparam logic [OPC_W-1:0] OPC_MOVE = 6'h03;
  localparam logic [OPC_W-1:0] ABSORB   = 6'h3F;

  function automatic logic [CG_W-1:0] pkt_cg(input logic [PKT_IN_W-1:0] p);
    return p[PKT_IN_W-1 -: CG_W];
  endfunction

  function automatic logic [DEST_W-1:0] pkt_dest(input logic [PKT_IN_W-1:0] p);
    return p[CZDD_W +: DEST_W];
  endfunction

  function automatic logic [CZDD_W-1:0] pkt_czdd(input logic [PKT_IN_W-1:0] p);
    return p[CZDD_W-1:0];
  endfunction

endpackage

// File: rtl/ps_stage_p_if.sv
// Packet handshake bundle of the PS stage: upstream valid/ready/packet in,
// downstream valid/ready/packet out. The slave modport is the stage side.
interface ps_stage_p_if #(
  parameter int IN_W  = ddp_ps_pkg::PKT_IN_W,
  parameter int OUT_W = ddp_ps_pkg::PKT_OUT_W
);
  logic             Send_in;
  logic [IN_W-1:0]  PACKET_IN;
  logic             Ack_out;
  logic             Send_out;
  logic [OUT_W-1:0] PACKET_OUT;
  logic             Ack_in;

  modport master (output Send_in, PACKET_IN, Ack_in,
                  input  Ack_out, Send_out, PACKET_OUT);
  modport slave  (input  Send_in, PACKET_IN, Ack_in,
                  output Ack_out, Send_out, PACKET_OUT);
endinterface

// File: rtl/ps_oq_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally. Storage is not reset, only pointers and count.
module ps_oq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CP,
  input  logic                     MR,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CP) begin
    if (push_i) mem[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ps_stage_p.sv
// PS stage: looks up PS[dest] for each accepted packet, forwards {CG, entry, CZDD}
// through an output queue, or absorbs it when the fetched opcode is ABSORB.
module ps_stage_p #(
  parameter int CG_W     = ddp_ps_pkg::CG_W,
  parameter int DEST_W   = ddp_ps_pkg::DEST_W,
  parameter int CZDD_W   = ddp_ps_pkg::CZDD_W,
  parameter int PSD_W    = ddp_ps_pkg::PSD_W,
  parameter int OPC_W    = ddp_ps_pkg::OPC_W,
  parameter int OQ_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic              CP,
  input  logic              MR,
  ps_stage_p_if.slave       bus,
  input  logic              PS_we,
  input  logic [DEST_W-1:0] PS_waddr,
  input  logic [PSD_W-1:0]  PS_wdata,
  output logic              ABS_out,
  output logic [CNT_W-1:0]  abs_cnt
);
  import ddp_ps_pkg::*;

  localparam int IN_W  = CG_W + DEST_W + CZDD_W;
  localparam int OUT_W = CG_W + PSD_W + CZDD_W;
  localparam int CW    = $clog2(OQ_DEPTH) + 1;

  logic [PSD_W-1:0]  ps_mem [2**DEST_W];
  logic [PSD_W-1:0]  rdata_q;
  logic              s1_valid_q, s1_valid_d;
  logic [CG_W-1:0]   cg_q, cg_d;
  logic [CZDD_W-1:0] czdd_q, czdd_d;
  logic              ack_q, ack_d;
  logic              abs_q, abs_d;
  logic [CNT_W-1:0]  abs_cnt_q, abs_cnt_d;
  logic              in_xfer_s, out_xfer_s, absorb_s, push_s, oq_valid_s;
  logic [CW-1:0]     oq_count_s, oq_count_nxt_s;
  logic [OUT_W-1:0]  merge_s, head_s;

  assign in_xfer_s  = bus.Send_in && ack_q;
  assign oq_valid_s = (oq_count_s != '0);
  assign out_xfer_s = oq_valid_s && bus.Ack_in;

  // Nonblocking read alongside the write yields the old entry on a same-address collision.
  always_ff @(posedge CP) begin
    if (PS_we) ps_mem[PS_waddr] <= PS_wdata;
    rdata_q <= ps_mem[bus.PACKET_IN[CZDD_W +: DEST_W]];
  end

  always_comb begin
    s1_valid_d = in_xfer_s;
    cg_d       = in_xfer_s ? bus.PACKET_IN[IN_W-1 -: CG_W] : cg_q;
    czdd_d     = in_xfer_s ? bus.PACKET_IN[CZDD_W-1:0] : czdd_q;
    absorb_s   = s1_valid_q && (rdata_q[OPC_W-1:0] == OPC_W'(ABSORB));
    push_s     = s1_valid_q && !absorb_s;
    merge_s    = {cg_q, rdata_q, czdd_q};
    abs_d      = absorb_s;
    abs_cnt_d  = (absorb_s && (abs_cnt_q != '1)) ? abs_cnt_q + CNT_W'(1) : abs_cnt_q;
    // Ready is registered from the post-edge occupancy so it equals (count + s1_valid) < depth.
    oq_count_nxt_s = oq_count_s + CW'(push_s) - CW'(out_xfer_s);
    ack_d          = (oq_count_nxt_s + CW'(s1_valid_d)) < CW'(OQ_DEPTH);
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      s1_valid_q <= 1'b0;
      cg_q       <= '0;
      czdd_q     <= '0;
      ack_q      <= 1'b0;
      abs_q      <= 1'b0;
      abs_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      cg_q       <= cg_d;
      czdd_q     <= czdd_d;
      ack_q      <= ack_d;
      abs_q      <= abs_d;
      abs_cnt_q  <= abs_cnt_d;
    end
  end

  ps_oq_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (OQ_DEPTH)
  ) u_oq (
    .CP      (CP),
    .MR      (MR),
    .push_i  (push_s),
    .din_i   (merge_s),
    .pop_i   (out_xfer_s),
    .dout_o  (head_s),
    .count_o (oq_count_s)
  );

  assign bus.Ack_out    = ack_q;
  assign bus.Send_out   = oq_valid_s;
  assign bus.PACKET_OUT = oq_valid_s ? head_s : '0;
  assign ABS_out        = abs_q;
  assign abs_cnt        = abs_cnt_q;

endmodule

// File: tb/tb_ps_stage_p.sv
// Randomized and directed bench for ps_stage_p against a queue-based model of
// the stage's transfer rules, plus literal expectations for the named scenarios.
module tb_ps_stage_p;
  import ddp_ps_pkg::*;

  logic CP = 1'b0;
  logic MR;
  logic PS_we;
  logic [DEST_W-1:0] PS_waddr;
  logic [PSD_W-1:0]  PS_wdata;
  logic ABS_out;
  logic [15:0] abs_cnt;

  ps_stage_p_if #(.IN_W(PKT_IN_W), .OUT_W(PKT_OUT_W)) bus ();

  ps_stage_p dut (
    .CP       (CP),
    .MR       (MR),
    .bus      (bus),
    .PS_we    (PS_we),
    .PS_waddr (PS_waddr),
    .PS_wdata (PS_wdata),
    .ABS_out  (ABS_out),
    .abs_cnt  (abs_cnt)
  );

  always #5 CP = ~CP;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PSD_W-1:0]     ps_m [128];
  logic [PKT_OUT_W-1:0] mq [$];
  logic                 s1_m = 1'b0;
  logic [CG_W-1:0]      s1_cg;
  logic [PSD_W-1:0]     s1_ent;
  logic [CZDD_W-1:0]    s1_czdd;
  logic                 ack_m = 1'b0;
  logic                 abs_m = 1'b0;
  logic [15:0]          cnt_m = 16'd0;

  always @(posedge CP or posedge MR) begin
    if (MR) begin
      mq.delete();
      s1_m  = 1'b0;
      ack_m = 1'b0;
      abs_m = 1'b0;
      cnt_m = 16'd0;
    end else begin
      if (mq.size() > 0 && bus.Ack_in) void'(mq.pop_front());
      abs_m = 1'b0;
      if (s1_m) begin
        if (s1_ent[OPC_W-1:0] == ABSORB) begin
          abs_m = 1'b1;
          if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end else begin
          mq.push_back({s1_cg, s1_ent, s1_czdd});
        end
      end
      s1_m = bus.Send_in && ack_m;
      if (s1_m) begin
        s1_cg   = pkt_cg(bus.PACKET_IN);
        s1_ent  = ps_m[pkt_dest(bus.PACKET_IN)];
        s1_czdd = pkt_czdd(bus.PACKET_IN);
      end
      if (PS_we) ps_m[PS_waddr] = PS_wdata;
      ack_m = (mq.size() + int'(s1_m)) < 4;
    end
  end

  // Compare every cycle mid-period against the model.
  always @(negedge CP) begin
    check("send_out", {63'd0, bus.Send_out}, {63'd0, mq.size() > 0});
    check("packet_out", {2'd0, bus.PACKET_OUT}, (mq.size() > 0) ? {2'd0, mq[0]} : 64'd0);
    check("ack_out", {63'd0, bus.Ack_out}, {63'd0, ack_m});
    check("abs_out", {63'd0, ABS_out}, {63'd0, abs_m});
    check("abs_cnt", {48'd0, abs_cnt}, {48'd0, cnt_m});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CP);
    #1;
  endtask

  function automatic logic [PKT_IN_W-1:0] mkpkt(input logic [CG_W-1:0] cg,
                                                input logic [DEST_W-1:0] d,
                                                input logic [CZDD_W-1:0] z);
    return {cg, d, z};
  endfunction

  task automatic rand_cycle(input bit allow_we);
    logic [PSD_W-1:0] w;
    bus.Send_in   = ($urandom_range(0, 3) != 0);
    bus.Ack_in    = ($urandom_range(0, 2) != 0);
    bus.PACKET_IN = mkpkt(CG_W'($urandom), DEST_W'($urandom), {2'($urandom), 32'($urandom)});
    PS_we    = allow_we && ($urandom_range(0, 4) == 0);
    PS_waddr = DEST_W'($urandom);
    w        = PSD_W'($urandom);
    if ($urandom_range(0, 3) == 0) w[OPC_W-1:0] = ABSORB;
    PS_wdata = w;
    cyc();
  endtask

  logic [PKT_OUT_W-1:0] e, got [$];
  logic [PSD_W-1:0]     v;
  logic [DEST_W-1:0]    d;
  int acc, n_abs, first, last, n_out;

  initial begin
    MR = 1'b1;
    PS_we = 1'b0; PS_waddr = '0; PS_wdata = '0;
    bus.Send_in = 1'b0; bus.PACKET_IN = '0; bus.Ack_in = 1'b0;

    // Reset
    repeat (3) cyc();
    check("rst_send_out", {63'd0, bus.Send_out}, 64'd0);
    check("rst_ack_out", {63'd0, bus.Ack_out}, 64'd0);
    MR = 1'b0;
    cyc();
    check("post_rst_ack", {63'd0, bus.Ack_out}, 64'd1);
    check("post_rst_cnt", {48'd0, abs_cnt}, 64'd0);

    // Preload PS without ABSORB opcodes
    for (int i = 0; i < 128; i++) begin
      v = PSD_W'($urandom);
      if (v[OPC_W-1:0] == ABSORB) v[OPC_W-1:0] = OPC_NOP;
      PS_we = 1'b1; PS_waddr = DEST_W'(i); PS_wdata = v;
      cyc();
    end

    // Basic forward
    bus.Ack_in = 1'b1;
    PS_waddr = 7'd3; PS_wdata = {7'd10, 4'hF, OPC_ADDC};
    cyc();
    PS_we = 1'b0;
    bus.Send_in = 1'b1; bus.PACKET_IN = mkpkt(11'h5, 7'd3, 34'h1234);
    cyc();
    bus.Send_in = 1'b0;
    cyc();
    e = {11'h5, 7'd10, 4'hF, OPC_ADDC, 34'h1234};
    check("fwd_send_out", {63'd0, bus.Send_out}, 64'd1);
    check("fwd_packet", {2'd0, bus.PACKET_OUT}, {2'd0, e});
    cyc(); cyc();

    // Absorb twice
    PS_we = 1'b1; PS_waddr = 7'd4; PS_wdata = {11'h2A, ABSORB};
    cyc();
    PS_we = 1'b0;
    bus.Send_in = 1'b1; bus.PACKET_IN = mkpkt(11'h1, 7'd4, 34'h77);
    cyc();
    n_abs = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.Send_in = 1'b0;
      cyc();
      n_abs += int'(ABS_out);
      check("abs_no_send", {63'd0, bus.Send_out}, 64'd0);
    end
    check("abs_pulses", 64'(n_abs), 64'd2);
    check("abs_cnt_2", {48'd0, abs_cnt}, 64'd2);

    // Backpressure: dest advances only when a packet is accepted
    bus.Ack_in = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.Send_in = 1'b1;
      bus.PACKET_IN = mkpkt(11'h3, DEST_W'(acc), 34'(acc));
      if (bus.Ack_out) acc++;
      cyc();
    end
    bus.Send_in = 1'b0;
    check("bp_accepted", 64'(acc), 64'd4);
    check("bp_ack_low", {63'd0, bus.Ack_out}, 64'd0);
    bus.Ack_in = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (bus.Send_out) got.push_back(bus.PACKET_OUT);
      cyc();
    end
    check("bp_delivered", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size(); i++)
      check("bp_order", 64'(got[i][33:0]), 64'(i));

    // Read/write collision on PS[9]
    PS_we = 1'b1; PS_waddr = 7'd9; PS_wdata = 17'h01C01;
    cyc();
    PS_wdata = 17'h15A02;
    bus.Send_in = 1'b1; bus.PACKET_IN = mkpkt(11'h7, 7'd9, 34'h9);
    cyc();
    PS_we = 1'b0;
    bus.PACKET_IN = mkpkt(11'h8, 7'd9, 34'hA);
    cyc();
    bus.Send_in = 1'b0;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      if (bus.Send_out) got.push_back(bus.PACKET_OUT);
      cyc();
    end
    check("col_count", 64'(got.size()), 64'd2);
    e = {11'h7, 17'h01C01, 34'h9};
    if (got.size() > 0) check("col_old", {2'd0, got[0]}, {2'd0, e});
    e = {11'h8, 17'h15A02, 34'hA};
    if (got.size() > 1) check("col_new", {2'd0, got[1]}, {2'd0, e});

    // Throughput: 100 back-to-back packets, none absorbed
    first = -1; last = -1; n_out = 0;
    for (int c = 0; c < 106; c++) begin
      bus.Send_in = (c < 100);
      d = DEST_W'($urandom);
      if (d == 7'd4) d = 7'd5;
      bus.PACKET_IN = mkpkt(CG_W'($urandom), d, 34'(c));
      cyc();
      if (bus.Send_out) begin
        n_out++;
        if (first < 0) first = c;
        last = c;
      end
    end
    bus.Send_in = 1'b0;
    check("tput_count", 64'(n_out), 64'd100);
    check("tput_span", 64'(last - first + 1), 64'd100);
    check("tput_latency", 64'(first), 64'd1);

    // Random traffic with a mid-stream reset
    for (int c = 0; c < 300; c++) begin
      if (c == 150) begin
        bus.Ack_in = 1'b0; bus.Send_in = 1'b1; PS_we = 1'b0;
        repeat (3) cyc();
        MR = 1'b1;
        bus.Send_in = 1'b0;
        #1;
        check("mr_send_out", {63'd0, bus.Send_out}, 64'd0);
        check("mr_packet_out", {2'd0, bus.PACKET_OUT}, 64'd0);
        cyc(); cyc();
        MR = 1'b0;
        cyc();
      end
      rand_cycle(1'b1);
    end
    PS_we = 1'b0; bus.Send_in = 1'b0; bus.Ack_in = 1'b1;
    repeat (8) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
